// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding and register-specifier constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_FREEZE      = 2'd1,
    ST_FREEZE_PEND = 2'd2
  } hz_state_e;

  localparam int REG_W_DEF = 5;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
// It holds at the all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core. It arbitrates memory freeze,
// EX redirect, load-use and ID branch, and defers redirects seen while frozen.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_busy_i,
  input  logic             redirect_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_hold_o,
  output logic             idex_bubble_o,
  output logic             frozen_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

  hz_state_e state_q;
  hz_state_e state_d;
  logic      frozen_q;
  logic      frozen_d;
  logic      lu;
  logic      redir;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      frozen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frozen_q <= frozen_d;
    end
  end

  // A redirect seen while the memory is busy is parked in FREEZE_PEND,
  // and later pulses are merged into that single pending flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy_i && redirect_i) state_d = ST_FREEZE_PEND;
        else if (mem_busy_i)          state_d = ST_FREEZE;
        else                          state_d = ST_RUN;
      end
      ST_FREEZE: begin
        if (mem_busy_i && redirect_i) state_d = ST_FREEZE_PEND;
        else if (mem_busy_i)          state_d = ST_FREEZE;
        else                          state_d = ST_RUN;
      end
      ST_FREEZE_PEND: begin
        state_d = mem_busy_i ? ST_FREEZE_PEND : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    frozen_d = (state_d != ST_RUN);
  end

  assign lu = ex_memread_i && (ex_rt_i != ZERO_R) &&
              ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  assign redir = redirect_i || (state_q == ST_FREEZE_PEND);

  // Reset drives the scrub pattern so both pipeline registers fill with NOPs.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_hold_o   = 1'b0;
    idex_bubble_o = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (mem_busy_i) begin
      pc_write_o  = 1'b0;
      ifid_hold_o = 1'b1;
      idex_hold_o = 1'b1;
    end else if (redir) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_hold_o   = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  assign frozen_o = frozen_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rst_i && !pc_write_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rst_i && ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule
